// File: rtl/ddr3_cache_sched.sv
// Arbitrates the DDR3 cache burst engine between two rx write-back channels and one tx fetch.
// Each channel owns a ring of frames; reads outside the last C_NUM_FRAMES written are rejected.
module ddr3_cache_sched #(
  parameter int unsigned C_ADDR_WIDTH = 32,
  parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
  parameter int unsigned C_BURST_BYTES = 256,
  parameter int unsigned C_WR_BURSTS = 64,
  parameter int unsigned C_NUM_FRAMES = 256,
  parameter int unsigned C_RD_STARVE = 4
) (
  input  logic                    M_AXI_ACLK,
  input  logic                    M_AXI_ARESET,
  input  logic                    init_calib_complete,
  input  logic [1:0]              wr_req,
  output logic [1:0]              wr_done,
  input  logic                    rd_req,
  input  logic                    rd_chan,
  input  logic [15:0]             rd_frame_num,
  input  logic [3:0]              rd_subframe_num,
  output logic                    rd_done,
  output logic                    rd_err,
  input  logic                    start_frame_update,
  input  logic [15:0]             start_frame,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic                    cmd_write,
  output logic                    cmd_chan,
  output logic [C_ADDR_WIDTH-1:0] cmd_addr,
  output logic [7:0]              cmd_bursts,
  input  logic                    cmd_done,
  output logic                    busy
);

  localparam int unsigned FrameBytes = C_WR_BURSTS * C_BURST_BYTES;
  localparam int unsigned SubBursts  = C_WR_BURSTS / 16;
  localparam int unsigned FIdxW      = $clog2(C_NUM_FRAMES);
  localparam logic [C_ADDR_WIDTH-1:0] RegionBytes = C_ADDR_WIDTH'(C_NUM_FRAMES * FrameBytes);
  localparam logic [C_ADDR_WIDTH-1:0] FrameBytesA = C_ADDR_WIDTH'(FrameBytes);
  localparam logic [C_ADDR_WIDTH-1:0] SubBytesA   = C_ADDR_WIDTH'(SubBursts * C_BURST_BYTES);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;
  state_e state_q, state_d;

  logic [1:0]              wr_armed_q;
  logic                    rd_armed_q;
  logic [15:0]             wr_cnt_q [2];
  logic [7:0]              rd_consec_q;
  logic                    rr_q;  // channel preferred when both writes pend
  logic                    sfu_q, load_pend_q;
  logic [15:0]             load_frame_q;
  logic                    rd_err_q, cmd_write_q, cmd_chan_q;
  logic [C_ADDR_WIDTH-1:0] cmd_addr_q;
  logic [7:0]              cmd_bursts_q;

  logic [1:0]              wr_pend;
  logic                    rd_pend, starve, grant_rd, grant_wr, wr_ch, rd_ok, sfu_edge;
  logic [15:0]             rd_diff, wr_frame;
  logic [C_ADDR_WIDTH-1:0] wr_addr, rd_addr;

  always_comb begin
    wr_pend  = wr_req & wr_armed_q;
    rd_pend  = rd_req & rd_armed_q;
    starve   = (32'(rd_consec_q) >= C_RD_STARVE) && (|wr_pend);
    grant_rd = (state_q == StIdle) && init_calib_complete && rd_pend && !starve;
    grant_wr = (state_q == StIdle) && init_calib_complete && (|wr_pend) && !grant_rd;
    wr_ch    = (&wr_pend) ? rr_q : wr_pend[1];
    sfu_edge = start_frame_update && !sfu_q;
    rd_diff  = wr_cnt_q[rd_chan] - rd_frame_num;
    rd_ok    = (rd_diff != 16'd0) && (32'(rd_diff) <= C_NUM_FRAMES);
    wr_frame = wr_cnt_q[wr_ch];
    wr_addr  = C_BASE_ADDR + (wr_ch ? RegionBytes : '0)
             + C_ADDR_WIDTH'(wr_frame[FIdxW-1:0]) * FrameBytesA;
    rd_addr  = C_BASE_ADDR + (rd_chan ? RegionBytes : '0)
             + C_ADDR_WIDTH'(rd_frame_num[FIdxW-1:0]) * FrameBytesA
             + C_ADDR_WIDTH'(rd_subframe_num) * SubBytesA;
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) state_q <= StIdle;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_rd)      state_d = rd_ok ? StIssue : StDone;
        else if (grant_wr) state_d = StIssue;
      end
      StIssue: if (cmd_ready) state_d = StWait;
      StWait:  if (cmd_done)  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_valid  = (state_q == StIssue);
    busy       = (state_q != StIdle);
    wr_done    = 2'b00;
    if (state_q == StDone && cmd_write_q) wr_done[cmd_chan_q] = 1'b1;
    rd_done    = (state_q == StDone) && !cmd_write_q;
    rd_err     = rd_done && rd_err_q;
    cmd_write  = cmd_write_q;
    cmd_chan   = cmd_chan_q;
    cmd_addr   = cmd_addr_q;
    cmd_bursts = cmd_bursts_q;
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      wr_armed_q   <= 2'b11;
      rd_armed_q   <= 1'b1;
      for (int i = 0; i < 2; i++) wr_cnt_q[i] <= 16'd0;
      rd_consec_q  <= 8'd0;
      rr_q         <= 1'b0;
      sfu_q        <= 1'b0;
      load_pend_q  <= 1'b0;
      load_frame_q <= 16'd0;
      rd_err_q     <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_chan_q   <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_bursts_q <= 8'd0;
    end else begin
      sfu_q <= start_frame_update;
      for (int i = 0; i < 2; i++) begin
        if (!wr_req[i])                          wr_armed_q[i] <= 1'b1;
        else if (grant_wr && wr_ch == 1'(i))     wr_armed_q[i] <= 1'b0;
      end
      if (!rd_req)       rd_armed_q <= 1'b1;
      else if (grant_rd) rd_armed_q <= 1'b0;

      if (grant_rd) begin
        cmd_write_q <= 1'b0;
        cmd_chan_q  <= rd_chan;
        rd_err_q    <= !rd_ok;
        if (rd_consec_q != 8'hff) rd_consec_q <= rd_consec_q + 8'd1;
        if (rd_ok) begin
          cmd_addr_q   <= rd_addr;
          cmd_bursts_q <= 8'(SubBursts);
        end
      end else if (grant_wr) begin
        cmd_write_q  <= 1'b1;
        cmd_chan_q   <= wr_ch;
        rd_err_q     <= 1'b0;
        rd_consec_q  <= 8'd0;
        rr_q         <= !wr_ch;
        cmd_addr_q   <= wr_addr;
        cmd_bursts_q <= 8'(C_WR_BURSTS);
      end

      // A load that arrived mid-command wins over the completing write's increment.
      if (state_q == StDone) begin
        if (load_pend_q || sfu_edge) begin
          for (int i = 0; i < 2; i++) wr_cnt_q[i] <= sfu_edge ? start_frame : load_frame_q;
          load_pend_q <= 1'b0;
        end else if (cmd_write_q) begin
          wr_cnt_q[cmd_chan_q] <= wr_cnt_q[cmd_chan_q] + 16'd1;
        end
      end else if (sfu_edge) begin
        if (state_q == StIdle) begin
          for (int i = 0; i < 2; i++) wr_cnt_q[i] <= start_frame;
        end else begin
          load_pend_q  <= 1'b1;
          load_frame_q <= start_frame;
        end
      end
    end
  end

endmodule
